// File: rtl/stream_merge_2to1.sv
`default_nettype none
// ============================================================================
// Module   : stream_merge_2to1
// Purpose  : Merges sample lanes A and B into one registered valid/ready
//            stream, using either a round-robin or a strict A,B interleave.
// Revision : 1.0  initial release
// ============================================================================
module stream_merge_2to1 #(
    parameter int N     = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [N-1:0]     a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [N-1:0]     b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic [N-1:0]     out_data,
    output logic             out_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count
);

    localparam logic c_LANE_A = 1'b0;
    localparam logic c_LANE_B = 1'b1;

    logic [N-1:0]     out_data_q,  out_data_d;
    logic             out_sel_q,   out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic             prio_q,      prio_d;

    logic w_load;
    logic w_grant_a;
    logic w_grant_b;

    // One-entry output register: refilled in the same cycle it drains.
    assign w_load = !out_valid_q || out_ready;

    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (prio_q == c_LANE_A) begin
            if (a_valid)
                w_grant_a = 1'b1;
            else if (!mode && b_valid)
                w_grant_b = 1'b1;
        end else begin
            if (b_valid)
                w_grant_b = 1'b1;
            else if (!mode && a_valid)
                w_grant_a = 1'b1;
        end
    end

    assign a_ready = w_load && !rst && w_grant_a;
    assign b_ready = w_load && !rst && w_grant_b;

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        prio_d      = prio_q;
        count_d     = count_q;
        if (out_valid_q && out_ready)
            count_d = count_q + CNT_W'(1);
        if (w_load) begin
            out_valid_d = a_ready || b_ready;
            if (a_ready) begin
                out_data_d = a_data;
                out_sel_d  = c_LANE_A;
                prio_d     = c_LANE_B;
            end else if (b_ready) begin
                out_data_d = b_data;
                out_sel_d  = c_LANE_B;
                prio_d     = c_LANE_A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_sel_q   <= c_LANE_A;
            out_valid_q <= 1'b0;
            count_q     <= '0;
            prio_q      <= c_LANE_A;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
            prio_q      <= prio_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;
    assign out_count = count_q;

endmodule
`default_nettype wire

// File: doc/stream_merge_2to1.md
Name: stream_merge_2to1

Overview:
- Recombines two N-bit sample lanes, A and B, into one registered output stream. Each lane and the output use a valid/ready handshake.
- This block is the inverse of the FIR datapath 1-to-2 demux. Its lane tag follows the same convention: sel=0 means A, sel=1 means B.
- It sits at the FIR path output, where it rejoins the polyphase/branch results.
- Mode 0 is a round-robin fair merge. Mode 1 is a strict A,B,A,B interleave, which restores the original sample order.

Parameters:
- N, 16, data width of each lane and of the output.
- CNT_W, 16, width of the output sample counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- mode  input  1  0 = round-robin merge; 1 = strict alternate interleave.
- a_data  input  N  lane A sample.
- a_valid  input  1  lane A sample present.
- a_ready  output  1  block accepts lane A this cycle.
- b_data  input  N  lane B sample.
- b_valid  input  1  lane B sample present.
- b_ready  output  1  block accepts lane B this cycle.
- out_data  output  N  merged sample, registered.
- out_sel  output  1  source lane of out_data (0=A, 1=B).
- out_valid  output  1  out_data/out_sel valid.
- out_ready  input  1  downstream accepts output.
- out_count  output  CNT_W  number of completed output handshakes, modulo 2^CNT_W.

Behaviour:
- Reset is synchronous and active-high on clk. While rst=1, all of the following hold on the next edge:
  - out_valid=0, out_data=0, out_sel=0, out_count=0.
  - Priority bit prio=0 (lane A preferred).
  - a_ready=b_ready=0 during any cycle in which rst=1.
- Reset asserted mid-transfer discards the held output word; no handshake completes in that cycle.
- Load enable: load = !out_valid | out_ready. This is a one-entry output register that is refilled in the same cycle it drains, giving full throughput of 1 sample/clk.
- Grant, evaluated combinationally from the registered prio, the valids, mode and load:
  - mode=0: grant the prio lane if its valid=1; otherwise grant the other lane if its valid=1; otherwise no grant.
  - mode=1: grant only the prio lane, and only if its valid=1. The other lane's valid is ignored and its ready stays 0.
  - Combined: a_ready = load & !rst & (granted lane == A), and likewise b_ready for B. At most one ready is high per cycle.
- An input handshake is lane_valid & lane_ready. On the next edge:
  - out_data <= lane data; out_sel <= lane id; out_valid <= 1.
  - prio <= ~lane id.
- Latency: exactly 1 clk from input handshake to out_valid.
- If load=1 and there is no grant, out_valid <= 0.
- Stall (out_valid=1, out_ready=0): out_data, out_sel and out_valid are held stable, and both readys are 0.
- out_count increments by 1 on each out_valid & out_ready and wraps from 2^CNT_W-1 to 0. If a handshake coincides with rst, rst wins.
- Mode change:
  - mode takes effect the same cycle it changes; prio is not reset.
  - Switching to mode 1 therefore continues from the lane after the last one granted.
  - In mode 1, a stalled prio lane blocks the output indefinitely. This is the intended strict-order behaviour.
- Simultaneous a_valid & b_valid in mode 0: prio decides. Sustained dual-valid yields the pattern A,B,A,B starting from prio.
- Inputs with valid=0 have no effect, whatever their data.

Test Plan:
- Reset then mode=0, a_valid=b_valid=1 continuously with A=0x0001,0x0002…, B=0x1001,0x1002…, out_ready=1 → output 0x0001,0x1001,0x0002,0x1002 with out_sel 0,1,0,1. First out_valid occurs 1 clk after the first handshake; then 1 sample/clk.
- mode=0, only b_valid=1 (data 0x00AA, 0x00BB), then a_valid=1 → B samples pass back-to-back despite prio=A. Once A appears, it is granted next because prio=A after a B grant.
- mode=1, b_valid=1 and a_valid=0 for 5 clks, then A=0x0123 → b_ready=0 for those 5 clks. Output sequence is 0x0123 (sel 0) then the held B sample (sel 1).
- Backpressure: out_valid=1 with out_data=0x5A5A, out_ready=0 for 3 clks → data/sel/valid stable and a_ready=b_ready=0. On out_ready=1 a new sample loads in the same cycle, and out_count increments exactly once.
- CNT_W=4 build, 17 output handshakes → out_count reads 0 after 16 handshakes and 1 after 17.
- rst pulsed while out_valid=1 and out_ready=1 → next cycle out_valid=0, out_count=0, prio=A, and no ready asserted during the rst cycle.
